// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the multi-lane serial ADC capture engine.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        QUIET   = 2'd2
    } adc_state_t;

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_CONVERT = CONVERT;
    localparam logic [1:0] S_QUIET   = QUIET;

    localparam int ADC_FRAME_CNT_W = 16;

    // Width of a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_capture_mc_if.sv
// Bus between the ADC capture engine and its consumer; the peak ports exist
// only when ADC_PEAK_HOLD_EN is defined.
interface adc_capture_mc_if #(
    parameter int NUM_LANES   = 4,
    parameter int SAMPLE_BITS = 12
) ();
    import adc_pkg::*;

    logic                              enable;
    logic                              ad_cs;
    logic [NUM_LANES-1:0]              ad_sdata;
    logic [NUM_LANES*SAMPLE_BITS-1:0]  sample;
    logic                              sample_valid;
    logic                              busy;
    logic [ADC_FRAME_CNT_W-1:0]        frame_count;
`ifdef ADC_PEAK_HOLD_EN
    logic                              peak_clear;
    logic [NUM_LANES*SAMPLE_BITS-1:0]  peak;
`endif

    modport master (
        input  enable, ad_sdata,
        output ad_cs, sample, sample_valid, busy, frame_count
`ifdef ADC_PEAK_HOLD_EN
        , input peak_clear, output peak
`endif
    );

    modport slave (
        output enable, ad_sdata,
        input  ad_cs, sample, sample_valid, busy, frame_count
`ifdef ADC_PEAK_HOLD_EN
        , output peak_clear, input peak
`endif
    );

endinterface

// File: rtl/adc_lane_shift.sv
// One lane's MSB-first deserialiser: shifts sdata in at the LSB while shift_en.
module adc_lane_shift #(
    parameter int SAMPLE_BITS = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic                   sdata,
    output logic [SAMPLE_BITS-1:0] shift_reg
);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[SAMPLE_BITS-2:0], sdata};
        end
    end

endmodule

// File: rtl/adc_capture_mc.sv
// Multi-lane serial ADC capture: drives shared ad_cs, deserialises each lane and
// strobes parallel samples. Optional per-lane peak hold under ADC_PEAK_HOLD_EN.
module adc_capture_mc
    import adc_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int SAMPLE_BITS  = 12,
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_BITS    = 4,
    parameter int QUIET_CYCLES = 1
) (
    input logic             clk,
    input logic             reset,
    adc_capture_mc_if.master bus
);

    localparam int BW = cnt_width(FRAME_BITS);
    localparam int QW = cnt_width(QUIET_CYCLES);
    localparam int SW = NUM_LANES * SAMPLE_BITS;

    logic [1:0]                 state_reg, state_next;
    logic [BW-1:0]              bit_cnt_reg, bit_cnt_next;
    logic [QW-1:0]              quiet_cnt_reg, quiet_cnt_next;
    logic                       ad_cs_reg;
    logic                       busy_reg;
    logic [SW-1:0]              sample_reg;
    logic                       sample_valid_reg;
    logic [ADC_FRAME_CNT_W-1:0] frame_count_reg;

    logic          frame_done;
    logic          quiet_done;
    logic          shift_en;
    logic [SW-1:0] capture_word;

    assign frame_done = (state_reg == S_CONVERT) && (bit_cnt_reg == BW'(FRAME_BITS - 1));
    assign quiet_done = (state_reg == S_QUIET) && (quiet_cnt_reg == QW'(QUIET_CYCLES - 1));
    assign shift_en   = (state_reg == S_CONVERT)
                     && (int'(bit_cnt_reg) >= LEAD_BITS)
                     && (int'(bit_cnt_reg) <  LEAD_BITS + SAMPLE_BITS);

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        quiet_cnt_next = quiet_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.enable) begin
                    state_next   = S_CONVERT;
                    bit_cnt_next = '0;
                end
            end
            S_CONVERT: begin
                if (frame_done) begin
                    state_next     = S_QUIET;
                    quiet_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + BW'(1);
                end
            end
            S_QUIET: begin
                if (quiet_done) begin
                    state_next   = bus.enable ? S_CONVERT : S_IDLE;
                    bit_cnt_next = '0;
                end else begin
                    quiet_cnt_next = quiet_cnt_reg + QW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ad_cs and busy are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            bit_cnt_reg      <= '0;
            quiet_cnt_reg    <= '0;
            ad_cs_reg        <= 1'b1;
            busy_reg         <= 1'b0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            frame_count_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            quiet_cnt_reg    <= quiet_cnt_next;
            ad_cs_reg        <= (state_next != S_CONVERT);
            busy_reg         <= (state_next != S_IDLE);
            sample_valid_reg <= frame_done;
            if (frame_done) begin
                sample_reg      <= capture_word;
                frame_count_reg <= frame_count_reg + ADC_FRAME_CNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [SAMPLE_BITS-1:0] shift_word;

            adc_lane_shift #(.SAMPLE_BITS(SAMPLE_BITS)) u_shift (
                .clk      (clk),
                .reset    (reset),
                .shift_en (shift_en),
                .sdata    (bus.ad_sdata[gi]),
                .shift_reg(shift_word)
            );

            // When the last data bit lands on the final CONVERT edge, fold it in here.
            assign capture_word[gi*SAMPLE_BITS +: SAMPLE_BITS] =
                shift_en ? {shift_word[SAMPLE_BITS-2:0], bus.ad_sdata[gi]} : shift_word;

`ifdef ADC_PEAK_HOLD_EN
            logic [SAMPLE_BITS-1:0] peak_reg;
            logic [SAMPLE_BITS-1:0] new_word;
            assign new_word = capture_word[gi*SAMPLE_BITS +: SAMPLE_BITS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    peak_reg <= '0;
                end else if (frame_done) begin
                    if (bus.peak_clear || (new_word > peak_reg)) begin
                        peak_reg <= new_word;
                    end
                end else if (bus.peak_clear) begin
                    peak_reg <= '0;
                end
            end

            assign bus.peak[gi*SAMPLE_BITS +: SAMPLE_BITS] = peak_reg;
`endif
        end
    endgenerate

    assign bus.ad_cs        = ad_cs_reg;
    assign bus.busy         = busy_reg;
    assign bus.sample       = sample_reg;
    assign bus.sample_valid = sample_valid_reg;
    assign bus.frame_count  = frame_count_reg;

endmodule
